// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, sync pulses, data-enable and start strobes.
// All outputs are registered from the same next-state values so they never skew against the counters.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ce,
    output logic [10:0] o_hcnt,
    output logic [10:0] o_vcnt,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_line_start,
    output logic        o_frame_start,
    output logic [7:0]  o_frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_FP_START   = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_BP_START   = 11'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_FP_START   = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_BP_START   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // state     | meaning
    // PH_ACTIVE | counter inside visible region
    // PH_FP     | front porch
    // PH_SYNC   | sync pulse asserted
    // PH_BP     | back porch (reset state, matches reset counters at H/V_TOTAL-1)
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    phase_t      h_phase, h_phase_nxt;
    phase_t      v_phase, v_phase_nxt;
    logic        h_wrap, v_wrap;
    logic [10:0] hcnt_nxt, vcnt_nxt;

    always_comb begin
        h_wrap   = (o_hcnt == H_LAST);
        v_wrap   = (o_vcnt == V_LAST);
        hcnt_nxt = h_wrap ? 11'd0 : o_hcnt + 11'd1;
        vcnt_nxt = o_vcnt;
        if (h_wrap) begin
            vcnt_nxt = v_wrap ? 11'd0 : o_vcnt + 11'd1;
        end
    end

    // Phases track the counter value that is about to be presented, so a
    // transition fires when the next count hits the first value of the next region.
    always_comb begin
        h_phase_nxt = h_phase;
        unique case (h_phase)
            PH_ACTIVE: if (hcnt_nxt == H_FP_START)   h_phase_nxt = PH_FP;
            PH_FP:     if (hcnt_nxt == H_SYNC_START) h_phase_nxt = PH_SYNC;
            PH_SYNC:   if (hcnt_nxt == H_BP_START)   h_phase_nxt = PH_BP;
            PH_BP:     if (hcnt_nxt == 11'd0)        h_phase_nxt = PH_ACTIVE;
            default:                                 h_phase_nxt = PH_BP;
        endcase
    end

    // Vertical phase only moves on the line wrap, keeping vsync line-aligned.
    always_comb begin
        v_phase_nxt = v_phase;
        if (h_wrap) begin
            unique case (v_phase)
                PH_ACTIVE: if (vcnt_nxt == V_FP_START)   v_phase_nxt = PH_FP;
                PH_FP:     if (vcnt_nxt == V_SYNC_START) v_phase_nxt = PH_SYNC;
                PH_SYNC:   if (vcnt_nxt == V_BP_START)   v_phase_nxt = PH_BP;
                PH_BP:     if (vcnt_nxt == 11'd0)        v_phase_nxt = PH_ACTIVE;
                default:                                 v_phase_nxt = PH_BP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_phase <= PH_BP;
            v_phase <= PH_BP;
        end else if (i_ce) begin
            h_phase <= h_phase_nxt;
            v_phase <= v_phase_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_hcnt        <= H_LAST;
            o_vcnt        <= V_LAST;
            o_hsync       <= ~H_POL;
            o_vsync       <= ~V_POL;
            o_de          <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_cnt   <= 8'd0;
        end else begin
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            if (i_ce) begin
                o_hcnt        <= hcnt_nxt;
                o_vcnt        <= vcnt_nxt;
                o_hsync       <= (h_phase_nxt == PH_SYNC) ? H_POL : ~H_POL;
                o_vsync       <= (v_phase_nxt == PH_SYNC) ? V_POL : ~V_POL;
                o_de          <= (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
                o_line_start  <= h_wrap;
                o_frame_start <= h_wrap && v_wrap;
                if (h_wrap && v_wrap) begin
                    o_frame_cnt <= o_frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule
